// File: rtl/buffer_ram_pkg.sv
// Shared types and helpers for the ping-pong console buffer.
// The capture length port is one bit wider than the lane address so a full bank can be reported.
package buffer_ram_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int calc_len_w(input int words, input int ratio);
    return $clog2(words * ratio) + 1;
  endfunction

endpackage

// File: rtl/dual_width_ram.sv
// Two-bank storage with a narrow lane write port and a wide registered word read port.
// Each lane column is its own array, so every column maps onto a plain simple-dual-port RAM.
module dual_width_ram #(
  parameter  int LANE_W = 16,
  parameter  int RATIO  = 2,
  parameter  int WORDS  = 256,
  localparam int CON_W  = LANE_W * RATIO,
  localparam int AW_W   = $clog2(WORDS * RATIO) + 1,
  localparam int AR_W   = $clog2(WORDS) + 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW_W-1:0]   waddr,
  input  logic [LANE_W-1:0] wdata,
  input  logic [AR_W-1:0]   raddr,
  output logic [CON_W-1:0]  rdata
);

  localparam int LS = $clog2(RATIO);

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    logic [LANE_W-1:0] mem [2*WORDS];
    logic [LANE_W-1:0] rd_q;
    logic              lane_we;
    logic [AR_W-1:0]   wword;

    // Low lane-address bits pick the column; the rest (bank included) pick the word.
    if (RATIO == 1) begin : g_one
      assign lane_we = we;
      assign wword   = waddr;
    end else begin : g_many
      assign lane_we = we && (waddr[LS-1:0] == LS'(gi));
      assign wword   = waddr[AW_W-1:LS];
    end

    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem[wword] <= wdata;
      end
      rd_q <= mem[raddr];
    end

    assign rdata[gi*LANE_W +: LANE_W] = rd_q;
  end

endmodule

// File: rtl/buffer_ram_pp.sv
// Ping-pong console buffer: the memory side fills one bank while the console reads the other,
// and a completed capture is handed over only when the console has released the previous one.
module buffer_ram_pp
  import buffer_ram_pkg::*;
#(
  parameter  int LANE_W = 16,
  parameter  int RATIO  = 2,
  parameter  int WORDS  = 256,
  localparam int CON_W  = LANE_W * RATIO,
  localparam int CA     = $clog2(WORDS),
  localparam int MA     = $clog2(WORDS * RATIO),
  localparam int LEN_W  = calc_len_w(WORDS, RATIO)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MEM_WE,
  input  logic [MA-1:0]     MEM_ADDR,
  input  logic [LANE_W-1:0] MEM_WD,
  input  logic              MEM_DONE,
  input  logic [CA-1:0]     CON_ADDR,
  output logic [CON_W-1:0]  CON_RD,
  output logic              CON_VALID,
  output logic [LEN_W-1:0]  CON_LEN,
  input  logic              CON_RELEASE,
  output logic              OVERFLOW
);

  localparam logic [LEN_W-1:0] WCNT_MAX = LEN_W'(WORDS * RATIO);

  state_e             state_q, state_d;
  logic               fb_q, fb_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               rd_live_q, rd_live_d;
  logic [LEN_W-1:0]   wcnt_inc;
  logic               swap;
  logic               drop;
  logic [CON_W-1:0]   ram_rd;

  // State register (with the bookkeeping that moves alongside it)
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_EMPTY;
      fb_q      <= 1'b0;
      wcnt_q    <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      rd_live_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fb_q      <= fb_d;
      wcnt_q    <= wcnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      rd_live_q <= rd_live_d;
    end
  end

  // A swap happens whenever the read bank is free, or is being freed in this very cycle.
  always_comb begin
    wcnt_inc = wcnt_q;
    if (MEM_WE && (wcnt_q != WCNT_MAX)) begin
      wcnt_inc = wcnt_q + LEN_W'(1);
    end
    swap = MEM_DONE && ((state_q == ST_EMPTY) || CON_RELEASE);
    drop = MEM_DONE && (state_q == ST_READY) && !CON_RELEASE;

    fb_d      = swap ? ~fb_q : fb_q;
    len_d     = swap ? wcnt_inc : len_q;
    wcnt_d    = swap ? '0 : wcnt_inc;
    ovf_d     = ovf_q | drop;
    rd_live_d = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (MEM_DONE) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (CON_RELEASE && !MEM_DONE) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    CON_VALID = (state_q == ST_READY);
    CON_LEN   = len_q;
    OVERFLOW  = ovf_q;
  end

  dual_width_ram #(
    .LANE_W (LANE_W),
    .RATIO  (RATIO),
    .WORDS  (WORDS)
  ) u_ram (
    .clk   (CLK),
    .we    (MEM_WE),
    .waddr ({fb_q, MEM_ADDR}),
    .wdata (MEM_WD),
    .raddr ({~fb_q, CON_ADDR}),
    .rdata (ram_rd)
  );

  // The storage has no reset; this flag holds the read port at zero from reset until the
  // first edge has refreshed the read register.
  assign CON_RD = rd_live_q ? ram_rd : '0;

endmodule
